// File: rtl/serial_addsub_ctrl.sv
// Nibble-serial add/subtract sequencer. Drives one shared 4-bit
// adder/subtractor datapath once per nibble (LSB nibble first), keeps the
// inter-nibble carry in a register, and returns sum/carry/overflow/zero
// over a valid/ready response port.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. Requests are taken only in IDLE (req_ready=1). The response
// is presented in DONE (rsp_valid=1) and held stable until rsp_ready is seen.
module serial_addsub_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_sub,
    input  logic [4*NIBBLES-1:0] req_a,
    input  logic [4*NIBBLES-1:0] req_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [4*NIBBLES-1:0] rsp_sum,
    output logic                 rsp_cout,
    output logic                 rsp_ovf,
    output logic                 rsp_zero,
    output logic [3:0]           dp_a,
    output logic [3:0]           dp_b,
    output logic                 dp_sub,
    output logic                 dp_cin,
    input  logic [3:0]           dp_sum,
    input  logic                 dp_cout,
    output logic [1:0]           dbg_state
);

    localparam int W     = 4 * NIBBLES;
    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [W-1:0]       a_q, a_d;
    logic [W-1:0]       b_q, b_d;
    logic               sub_q, sub_d;
    logic               carry_q, carry_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [W-1:0]       sum_q, sum_d;
    logic               msb_a_q, msb_a_d;
    logic               msb_b_q, msb_b_d;
    logic               rsp_cout_q, rsp_cout_d;
    logic               rsp_ovf_q, rsp_ovf_d;
    logic               rsp_zero_q, rsp_zero_d;

    logic               last_nibble;
    logic [3:0]         a_nib;
    logic [3:0]         b_nib;
    logic [W-1:0]       sum_merged;

    assign last_nibble = (idx_q == LAST_IDX);

    // Select the current operand nibbles and merge the datapath result into the sum
    always_comb begin
        a_nib      = '0;
        b_nib      = '0;
        sum_merged = sum_q;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                a_nib                 = a_q[4*i +: 4];
                b_nib                 = b_q[4*i +: 4];
                sum_merged[4*i +: 4]  = dp_sum;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic: RUN lasts exactly NIBBLES cycles
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req_valid)   state_d = S_RUN;
            S_RUN:   if (last_nibble) state_d = S_DONE;
            S_DONE:  if (rsp_ready)   state_d = S_IDLE;
            default:                  state_d = S_IDLE;
        endcase
    end

    // FSM outputs: handshake flags and datapath drive (zero outside RUN)
    always_comb begin
        req_ready = (state_q == S_IDLE);
        rsp_valid = (state_q == S_DONE);
        dp_a      = '0;
        dp_b      = '0;
        dp_sub    = 1'b0;
        dp_cin    = 1'b0;
        if (state_q == S_RUN) begin
            dp_a   = a_nib;
            dp_b   = b_nib;
            dp_sub = sub_q;
            dp_cin = carry_q;
        end
    end

    // Operand capture, per-nibble accumulation and final flag computation
    always_comb begin
        a_d        = a_q;
        b_d        = b_q;
        sub_d      = sub_q;
        carry_d    = carry_q;
        idx_d      = idx_q;
        sum_d      = sum_q;
        msb_a_d    = msb_a_q;
        msb_b_d    = msb_b_q;
        rsp_cout_d = rsp_cout_q;
        rsp_ovf_d  = rsp_ovf_q;
        rsp_zero_d = rsp_zero_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    a_d     = req_a;
                    b_d     = req_b;
                    sub_d   = req_sub;
                    // Subtraction is A + ~B + 1: the +1 enters as the first carry.
                    carry_d = req_sub;
                    idx_d   = '0;
                    msb_a_d = req_a[W-1];
                    msb_b_d = req_b[W-1];
                end
            end
            S_RUN: begin
                sum_d   = sum_merged;
                carry_d = dp_cout;
                if (last_nibble) begin
                    idx_d      = '0;
                    rsp_cout_d = dp_cout;
                    // Overflow: effective operand signs agree but result sign differs.
                    rsp_ovf_d  = (msb_a_q == (msb_b_q ^ sub_q)) && (dp_sum[3] != msb_a_q);
                    rsp_zero_d = (sum_merged == '0);
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q        <= '0;
            b_q        <= '0;
            sub_q      <= 1'b0;
            carry_q    <= 1'b0;
            idx_q      <= '0;
            sum_q      <= '0;
            msb_a_q    <= 1'b0;
            msb_b_q    <= 1'b0;
            rsp_cout_q <= 1'b0;
            rsp_ovf_q  <= 1'b0;
            rsp_zero_q <= 1'b0;
        end else begin
            a_q        <= a_d;
            b_q        <= b_d;
            sub_q      <= sub_d;
            carry_q    <= carry_d;
            idx_q      <= idx_d;
            sum_q      <= sum_d;
            msb_a_q    <= msb_a_d;
            msb_b_q    <= msb_b_d;
            rsp_cout_q <= rsp_cout_d;
            rsp_ovf_q  <= rsp_ovf_d;
            rsp_zero_q <= rsp_zero_d;
        end
    end

    assign rsp_sum   = sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_ovf   = rsp_ovf_q;
    assign rsp_zero  = rsp_zero_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Bench for serial_addsub_ctrl: a 4-nibble and a 2-nibble instance, each
// looped back through a behavioural 4-bit adder/subtractor. Results are
// compared against a word-level arithmetic reference model.
module tb_serial_addsub_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    logic [18:0] exp_q[$];

    // shared drivers; sel=0 targets the 4-nibble DUT, sel=1 the 2-nibble DUT
    logic        sel = 1'b0;
    logic        req_valid_drv = 1'b0;
    logic        rsp_ready_drv = 1'b0;
    logic        req_sub_drv   = 1'b0;
    logic [15:0] req_a_drv     = '0;
    logic [15:0] req_b_drv     = '0;

    // ---------------- DUT, NIBBLES=4 ----------------
    logic        req_valid4, rsp_ready4, req_ready4, rsp_valid4;
    logic [15:0] rsp_sum4;
    logic        rsp_cout4, rsp_ovf4, rsp_zero4;
    logic [3:0]  dp_a4, dp_b4, dp_sum4;
    logic        dp_sub4, dp_cin4, dp_cout4;
    logic [1:0]  dbg4;

    assign req_valid4 = req_valid_drv & ~sel;
    assign rsp_ready4 = rsp_ready_drv & ~sel;
    assign {dp_cout4, dp_sum4} = {1'b0, dp_a4} + {1'b0, dp_b4 ^ {4{dp_sub4}}} + {4'b0, dp_cin4};

    serial_addsub_ctrl #(.NIBBLES(4)) u_dut4 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid4), .req_ready(req_ready4), .req_sub(req_sub_drv),
        .req_a(req_a_drv), .req_b(req_b_drv),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4), .rsp_sum(rsp_sum4),
        .rsp_cout(rsp_cout4), .rsp_ovf(rsp_ovf4), .rsp_zero(rsp_zero4),
        .dp_a(dp_a4), .dp_b(dp_b4), .dp_sub(dp_sub4), .dp_cin(dp_cin4),
        .dp_sum(dp_sum4), .dp_cout(dp_cout4), .dbg_state(dbg4)
    );

    // ---------------- DUT, NIBBLES=2 ----------------
    logic        req_valid2, rsp_ready2, req_ready2, rsp_valid2;
    logic [7:0]  rsp_sum2;
    logic        rsp_cout2, rsp_ovf2, rsp_zero2;
    logic [3:0]  dp_a2, dp_b2, dp_sum2;
    logic        dp_sub2, dp_cin2, dp_cout2;
    logic [1:0]  dbg2;

    assign req_valid2 = req_valid_drv & sel;
    assign rsp_ready2 = rsp_ready_drv & sel;
    assign {dp_cout2, dp_sum2} = {1'b0, dp_a2} + {1'b0, dp_b2 ^ {4{dp_sub2}}} + {4'b0, dp_cin2};

    serial_addsub_ctrl #(.NIBBLES(2)) u_dut2 (
        .clk(clk), .rst(rst),
        .req_valid(req_valid2), .req_ready(req_ready2), .req_sub(req_sub_drv),
        .req_a(req_a_drv[7:0]), .req_b(req_b_drv[7:0]),
        .rsp_valid(rsp_valid2), .rsp_ready(rsp_ready2), .rsp_sum(rsp_sum2),
        .rsp_cout(rsp_cout2), .rsp_ovf(rsp_ovf2), .rsp_zero(rsp_zero2),
        .dp_a(dp_a2), .dp_b(dp_b2), .dp_sub(dp_sub2), .dp_cin(dp_cin2),
        .dp_sum(dp_sum2), .dp_cout(dp_cout2), .dbg_state(dbg2)
    );

    // views of the currently selected DUT
    logic        cur_req_ready, cur_rsp_valid, cur_dp_cin, cur_dp_sub;
    logic [18:0] cur_rsp;
    assign cur_req_ready = sel ? req_ready2 : req_ready4;
    assign cur_rsp_valid = sel ? rsp_valid2 : rsp_valid4;
    assign cur_dp_cin    = sel ? dp_cin2 : dp_cin4;
    assign cur_dp_sub    = sel ? dp_sub2 : dp_sub4;
    assign cur_rsp = sel ? {rsp_zero2, rsp_ovf2, rsp_cout2, 8'h00, rsp_sum2}
                         : {rsp_zero4, rsp_ovf4, rsp_cout4, rsp_sum4};

    // ---------------- reference model ----------------
    // Word-level arithmetic: returns {zero, ovf, cout, sum[15:0]}.
    function automatic logic [18:0] model(input int w, input logic [15:0] a,
                                          input logic [15:0] b, input logic sub);
        longint mask, ua, ub, full, s, half, sa, sb, r;
        logic   cout, ovf, zero;
        mask = (longint'(1) << w) - 1;
        half = longint'(1) << (w - 1);
        ua   = longint'(a) & mask;
        ub   = longint'(b) & mask;
        full = sub ? (ua + ((~ub) & mask) + 1) : (ua + ub);
        s    = full & mask;
        cout = ((full >> w) & 1) != 0;
        sa   = (ua >= half) ? ua - 2 * half : ua;
        sb   = (ub >= half) ? ub - 2 * half : ub;
        r    = sub ? sa - sb : sa + sb;
        ovf  = (r >= half) || (r < -half);
        zero = (s == 0);
        return {zero, ovf, cout, 16'(s)};
    endfunction

    // ---------------- driver + scoreboard ----------------
    // Issues one request on the selected DUT, checks exact latency, holds the
    // response for 'hold' cycles (optionally presenting a next request), then
    // retires it. Records dp_cin / dp_sub per RUN cycle.
    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                          input int hold, input logic nx_v, input logic [15:0] nx_a,
                          input logic [15:0] nx_b, input logic nx_sub,
                          output logic [7:0] cin_seq, output logic [7:0] sub_seq);
        int n;
        int waited;
        logic [18:0] got, exp;
        n = sel ? 2 : 4;
        cin_seq = '0;
        sub_seq = '0;
        waited = 0;
        while (cur_req_ready !== 1'b1 && waited < 20) begin
            @(posedge clk); #1; waited++;
        end
        checks++;
        if (cur_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL accept_wait req_ready=%b expected 1", cur_req_ready);
            req_valid_drv = 1'b0;
            return;
        end
        req_valid_drv = 1'b1;
        req_a_drv = a; req_b_drv = b; req_sub_drv = sub;
        @(posedge clk); #1;
        req_valid_drv = 1'b0;
        req_a_drv = 16'($urandom); req_b_drv = 16'($urandom); req_sub_drv = 1'($urandom);
        for (int k = 0; k < n; k++) begin
            cin_seq[k] = cur_dp_cin;
            sub_seq[k] = cur_dp_sub;
            checks++;
            if (cur_rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL latency_early cycle=%0d rsp_valid=%b expected 0", k, cur_rsp_valid);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (cur_rsp_valid !== 1'b1) begin
            failures++;
            $display("FAIL latency rsp_valid=%b expected 1 after %0d cycles", cur_rsp_valid, n);
            waited = 0;
            while (cur_rsp_valid !== 1'b1 && waited < 20) begin
                @(posedge clk); #1; waited++;
            end
            if (cur_rsp_valid !== 1'b1) return;
        end
        got = cur_rsp;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL scoreboard_empty got=%h", got);
        end else begin
            exp = exp_q.pop_front();
            if (got !== exp) begin
                failures++;
                $display("FAIL result a=%h b=%h sub=%b got{z,o,c,sum}=%h expected=%h",
                         a, b, sub, got, exp);
            end
        end
        for (int h = 0; h < hold; h++) begin
            if (nx_v) begin
                req_valid_drv = 1'b1;
                req_a_drv = nx_a; req_b_drv = nx_b; req_sub_drv = nx_sub;
            end
            @(posedge clk); #1;
            checks++;
            if (cur_rsp !== got || cur_rsp_valid !== 1'b1) begin
                failures++;
                $display("FAIL hold_stable cycle=%0d rsp=%h valid=%b expected %h valid 1",
                         h, cur_rsp, cur_rsp_valid, got);
            end
            checks++;
            if (cur_req_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_req_ready cycle=%0d req_ready=%b expected 0", h, cur_req_ready);
            end
        end
        rsp_ready_drv = 1'b1;
        @(posedge clk); #1;
        rsp_ready_drv = 1'b0;
        checks++;
        if (cur_rsp_valid !== 1'b0 || cur_req_ready !== 1'b1) begin
            failures++;
            $display("FAIL retire rsp_valid=%b req_ready=%b expected 0 1", cur_rsp_valid, cur_req_ready);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({req_ready4, rsp_valid4, req_ready2, rsp_valid2} !== 4'b1010) begin
            failures++;
            $display("FAIL reset_handshake got=%b expected 1010",
                     {req_ready4, rsp_valid4, req_ready2, rsp_valid2});
        end
        checks++;
        if ({rsp_sum4, rsp_cout4, rsp_ovf4, rsp_zero4} !== 19'd0) begin
            failures++;
            $display("FAIL reset_rsp4 got=%h expected 0", {rsp_sum4, rsp_cout4, rsp_ovf4, rsp_zero4});
        end
        checks++;
        if ({rsp_sum2, rsp_cout2, rsp_ovf2, rsp_zero2} !== 11'd0) begin
            failures++;
            $display("FAIL reset_rsp2 got=%h expected 0", {rsp_sum2, rsp_cout2, rsp_ovf2, rsp_zero2});
        end
        checks++;
        if ({dp_a4, dp_b4, dp_sub4, dp_cin4, dp_a2, dp_b2, dp_sub2, dp_cin2} !== 20'd0) begin
            failures++;
            $display("FAIL reset_dp got=%h expected 0",
                     {dp_a4, dp_b4, dp_sub4, dp_cin4, dp_a2, dp_b2, dp_sub2, dp_cin2});
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        logic [7:0] cs, ss;
        sel = 1'b0;
        exp_q.push_back({1'b0, 1'b0, 1'b0, 16'h5555});
        run_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0, 16'h0, 16'h0, 1'b0, cs, ss);
        checks++;
        if (cs[3:0] !== 4'b0000 || ss[3:0] !== 4'b0000) begin
            failures++;
            $display("FAIL add_dp_seq cin=%b sub=%b expected 0000 0000", cs[3:0], ss[3:0]);
        end
    endtask

    task automatic test_carry_chain();
        logic [7:0] cs, ss;
        sel = 1'b0;
        exp_q.push_back({1'b0, 1'b1, 1'b0, 16'h8000});
        run_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0, 16'h0, 16'h0, 1'b0, cs, ss);
        checks++;
        // bit k holds dp_cin of nibble k: sequence 0,1,1,1
        if (cs[3:0] !== 4'b1110) begin
            failures++;
            $display("FAIL carry_cin_seq got=%b expected 1110", cs[3:0]);
        end
        exp_q.push_back({1'b1, 1'b0, 1'b1, 16'h0000});
        run_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0, 16'h0, 16'h0, 1'b0, cs, ss);
    endtask

    task automatic test_subtract();
        logic [7:0] cs, ss;
        sel = 1'b0;
        exp_q.push_back({1'b0, 1'b0, 1'b0, 16'hFFFF});
        run_op(16'h0000, 16'h0001, 1'b1, 0, 1'b0, 16'h0, 16'h0, 1'b0, cs, ss);
        checks++;
        if (cs[0] !== 1'b1 || ss[3:0] !== 4'b1111) begin
            failures++;
            $display("FAIL sub_dp_seq first_cin=%b sub=%b expected 1 1111", cs[0], ss[3:0]);
        end
        exp_q.push_back({1'b0, 1'b1, 1'b1, 16'h7FFF});
        run_op(16'h8000, 16'h0001, 1'b1, 0, 1'b0, 16'h0, 16'h0, 1'b0, cs, ss);
        exp_q.push_back({1'b1, 1'b0, 1'b1, 16'h0000});
        run_op(16'h1234, 16'h1234, 1'b1, 0, 1'b0, 16'h0, 16'h0, 1'b0, cs, ss);
    endtask

    task automatic test_backpressure();
        logic [7:0] cs, ss;
        sel = 1'b0;
        exp_q.push_back({1'b0, 1'b0, 1'b0, 16'h3333});
        exp_q.push_back({1'b0, 1'b0, 1'b1, 16'h00FF});
        run_op(16'h1111, 16'h2222, 1'b0, 5, 1'b1, 16'h0100, 16'h0001, 1'b1, cs, ss);
        run_op(16'h0100, 16'h0001, 1'b1, 0, 1'b0, 16'h0, 16'h0, 1'b0, cs, ss);
    endtask

    task automatic test_reset_mid();
        logic [7:0] cs, ss;
        logic       seen;
        sel = 1'b0;
        req_valid_drv = 1'b1;
        req_a_drv = 16'hAAAA; req_b_drv = 16'h5555; req_sub_drv = 1'b0;
        @(posedge clk); #1;                 // accepted; first RUN cycle
        req_valid_drv = 1'b0;
        @(posedge clk); #1;                 // second RUN cycle
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (req_ready4 !== 1'b1 || rsp_valid4 !== 1'b0) begin
            failures++;
            $display("FAIL midrst_handshake req_ready=%b rsp_valid=%b expected 1 0", req_ready4, rsp_valid4);
        end
        checks++;
        if ({rsp_sum4, rsp_cout4, rsp_ovf4, rsp_zero4, dp_a4, dp_b4, dp_sub4, dp_cin4} !== 29'd0) begin
            failures++;
            $display("FAIL midrst_outputs got=%h expected 0",
                     {rsp_sum4, rsp_cout4, rsp_ovf4, rsp_zero4, dp_a4, dp_b4, dp_sub4, dp_cin4});
        end
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (rsp_valid4 === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin
            failures++;
            $display("FAIL midrst_no_rsp rsp_valid_seen=%b expected 0", seen);
        end
        exp_q.push_back({1'b0, 1'b0, 1'b0, 16'h1000});
        run_op(16'h0F0F, 16'h00F1, 1'b0, 0, 1'b0, 16'h0, 16'h0, 1'b0, cs, ss);
    endtask

    task automatic test_small_width();
        logic [7:0] cs, ss;
        sel = 1'b1;
        exp_q.push_back({1'b0, 1'b1, 1'b0, 16'h0080});
        run_op(16'h007F, 16'h0001, 1'b0, 0, 1'b0, 16'h0, 16'h0, 1'b0, cs, ss);
        checks++;
        if (cs[1:0] !== 2'b10) begin
            failures++;
            $display("FAIL small_cin_seq got=%b expected 10", cs[1:0]);
        end
    endtask

    task automatic test_random(input logic use_small, input int n_ops);
        logic [7:0]  cs, ss;
        logic [15:0] a, b;
        logic        sub;
        int          w;
        sel = use_small;
        w = use_small ? 8 : 16;
        for (int i = 0; i < n_ops; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            case ($urandom_range(0, 7))
                0: a = 16'h0000;
                1: b = 16'hFFFF;
                2: a = use_small ? 16'h0080 : 16'h8000;
                3: b = use_small ? 16'h007F : 16'h7FFF;
                4: b = a;
                default: ;
            endcase
            if (use_small) begin
                a[15:8] = 8'h00;
                b[15:8] = 8'h00;
            end
            sub = 1'($urandom_range(0, 1));
            exp_q.push_back(model(w, a, b, sub));
            run_op(a, b, sub, int'($urandom_range(0, 2)), 1'b0, 16'h0, 16'h0, 1'b0, cs, ss);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_add();
        test_carry_chain();
        test_subtract();
        test_backpressure();
        test_reset_mid();
        test_small_width();
        test_random(1'b1, 1000);
        test_random(1'b0, 300);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_leftover entries=%0d expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

endmodule
